// File: rtl/estimation_pkg.sv
// Shared defaults and FSM encoding for the activity estimator.
package estimation_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_WIN_LOG2 = 8;
  localparam int DEF_RECOV_CH = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } est_state_e;

endpackage

// File: rtl/est_sat_counter.sv
// Saturating event counter. o_value_incl is the count including this cycle's
// increment, so a window close can capture it without waiting a cycle.
module est_sat_counter
  import estimation_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_restart,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_value_incl
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_value_incl;

  assign w_value_incl = (i_inc && (r_count != CNT_MAX)) ? r_count + 1'b1 : r_count;
  assign o_value_incl = w_value_incl;

  // Restart drops the current value; the increment it would have taken has
  // already been handed out through o_value_incl.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear || i_restart) begin
      r_count <= '0;
    end else begin
      r_count <= w_value_incl;
    end
  end

endmodule

// File: rtl/activity_estimator.sv
// Windowed event-activity counters with a held snapshot handshake and a
// longest-run tracker on the recovery channel.
module activity_estimator
  import estimation_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int RECOV_CH = DEF_RECOV_CH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       event_in,
  input  logic                    snap_ack,
  output logic                    snap_valid,
  output logic [NUM_CH*CNT_W-1:0] win_count,
  output logic [7:0]              win_seq,
  output logic [CNT_W-1:0]        max_run,
  output logic                    snap_overrun,
  output logic                    busy
);

  // Snapshot handshake: snap_valid rises the cycle after a window close and
  // holds win_count/win_seq stable until a cycle with snap_valid && snap_ack.
  // A close in that same cycle reloads the snapshot; a close without ack
  // leaves it untouched and sets the sticky snap_overrun.

  est_state_e              r_state;
  est_state_e              w_state_next;
  logic [WIN_LOG2-1:0]     r_wcnt;
  logic                    w_close;
  logic                    w_accept;
  logic [NUM_CH*CNT_W-1:0] w_totals;
  logic [CNT_W-1:0]        w_run_incl;
  logic                    w_recov_hit;
  logic [CNT_W-1:0]        r_max_run;
  logic                    r_snap_valid;
  logic [NUM_CH*CNT_W-1:0] r_win_count;
  logic [7:0]              r_win_seq;
  logic                    r_overrun;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (enable)  w_state_next = ST_RUN;
      ST_RUN:  if (!enable) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (clear) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign busy = (r_state == ST_RUN);

  // Every enabled cycle advances the window; disabled cycles hold it in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt <= '0;
    end else if (clear) begin
      r_wcnt <= '0;
    end else if (enable) begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

  assign w_close  = enable && (&r_wcnt);
  assign w_accept = !r_snap_valid || snap_ack;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    est_sat_counter #(.CNT_W(CNT_W)) u_live (
      .i_clk        (clk),
      .i_rst_n      (reset),
      .i_clear      (clear),
      .i_restart    (w_close),
      .i_inc        (enable & event_in[g]),
      .o_value_incl (w_totals[g*CNT_W +: CNT_W])
    );
  end

  assign w_recov_hit = enable & event_in[RECOV_CH];

  est_sat_counter #(.CNT_W(CNT_W)) u_run (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_clear      (clear),
    .i_restart    (enable & ~event_in[RECOV_CH]),
    .i_inc        (w_recov_hit),
    .o_value_incl (w_run_incl)
  );

  // w_run_incl already counts the current high cycle and saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max_run <= '0;
    end else if (clear) begin
      r_max_run <= '0;
    end else if (w_recov_hit && (w_run_incl > r_max_run)) begin
      r_max_run <= w_run_incl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap_valid <= 1'b0;
      r_win_count  <= '0;
      r_win_seq    <= '0;
      r_overrun    <= 1'b0;
    end else if (clear) begin
      r_snap_valid <= 1'b0;
      r_win_count  <= '0;
      r_win_seq    <= '0;
      r_overrun    <= 1'b0;
    end else if (w_close) begin
      if (w_accept) begin
        r_win_count  <= w_totals;
        r_win_seq    <= r_win_seq + 1'b1;
        r_snap_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (snap_ack) begin
      r_snap_valid <= 1'b0;
    end
  end

  assign snap_valid   = r_snap_valid;
  assign win_count    = r_win_count;
  assign win_seq      = r_win_seq;
  assign max_run      = r_max_run;
  assign snap_overrun = r_overrun;

endmodule

// File: doc/activity_estimator.md
ACTIVITY_ESTIMATOR -- requirements
Module: activity_estimator

Interface
REQ-001 Parameter NUM_CH, default 4, number of tapped event channels (bit 0 pc_write, 1 reg_write, 2 mem_write, 3 recovery_active at default).
REQ-002 Parameter CNT_W, default 16, width of every count and run-length value.
REQ-003 Parameter WIN_LOG2, default 8, observation window is 2^WIN_LOG2 enabled cycles.
REQ-004 Parameter RECOV_CH, default 3, channel index whose consecutive-high run length is tracked.
REQ-005 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port enable  input  1  counting enabled; low pauses the window.
REQ-008 Port clear  input  1  synchronous clear of all state.
REQ-009 Port event_in  input  NUM_CH  read-only tapped event strobes, one per channel.
REQ-010 Port snap_ack  input  1  consumer accepts current snapshot.
REQ-011 Port snap_valid  output  1  snapshot available, held until acknowledged.
REQ-012 Port win_count  output  NUM_CH*CNT_W  snapshot counts, channel i at bits [i*CNT_W +: CNT_W].
REQ-013 Port win_seq  output  8  sequence number of the loaded snapshot.
REQ-014 Port max_run  output  CNT_W  longest consecutive-high run seen on RECOV_CH since reset/clear.
REQ-015 Port snap_overrun  output  1  sticky: a window closed while an unacknowledged snapshot was pending.
REQ-016 Port busy  output  1  high while FSM is in RUN.

Function
REQ-017 FSM states IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0; busy=1 exactly in RUN.
REQ-018 In RUN, per cycle: window counter wcnt (WIN_LOG2 bits) increments; live counter i increments when event_in[i]=1.
REQ-019 Live counters and max_run saturate at 2^CNT_W-1 and never wrap.
REQ-020 Events and wcnt are ignored/held while enable=0; a paused window resumes at the held wcnt.
REQ-021 Window closes in the RUN cycle where wcnt is all-ones; that cycle's events are included in the snapshot.
REQ-022 On close with snap_valid=0, or snap_valid=1 and snap_ack=1 same cycle: win_count loads closing totals, win_seq increments (wraps 255->0), snap_valid=1 next cycle.
REQ-023 On close with snap_valid=1 and snap_ack=0: win_count and win_seq unchanged, snap_overrun set and held until reset/clear.
REQ-024 Live counters restart from 0 (plus that next cycle's events) on the cycle after every close, regardless of snapshot acceptance.
REQ-025 snap_ack with snap_valid=1 and no close clears snap_valid next cycle; snap_ack with snap_valid=0 has no effect.
REQ-026 Run counter increments each RUN cycle RECOV_CH is high, resets to 0 on a RUN cycle where it is low; max_run updates to run counter +1 when that exceeds it, same cycle latency of one clock; runs span window boundaries.
REQ-027 clear has priority over all other inputs and zeroes every register and output next cycle; FSM goes to IDLE.

Reset
REQ-028 reset=0 asynchronously forces IDLE, wcnt=0, all live counters=0, run counter=0, snap_valid=0, win_count=0, win_seq=0, max_run=0, snap_overrun=0, busy=0.
REQ-029 Reset mid-window discards the partial window; first window after release starts at wcnt=0.

Structure
REQ-030 Package estimation_pkg holds the FSM state enum and default values of NUM_CH, CNT_W, WIN_LOG2, RECOV_CH.
REQ-031 Sub-module est_sat_counter (CNT_W-wide saturating counter with inc, restart and clear) is instantiated once per channel plus once for the run counter.

Verification
REQ-032 NUM_CH=4, CNT_W=8, WIN_LOG2=4: ch0 high 16 cycles, ch1 every other cycle -> snap_valid cycle 17, win_count ch0=16, ch1=8, ch2=ch3=0, win_seq=1.
REQ-033 CNT_W=4, WIN_LOG2=5, ch0 constantly high -> ch0 snapshot=15 (saturated), no wrap.
REQ-034 No snap_ack across two windows -> snap_overrun=1, win_count still window-1 values, win_seq=1; repeat with ack on close cycle -> win_seq=2, overrun=0.
REQ-035 RECOV_CH high 5 cycles, low 1, high 3, run straddling a window close -> max_run=5; then clear -> all outputs 0 next cycle.
REQ-036 enable low 10 cycles after 6 window cycles -> close after 16 enabled cycles (26 elapsed); reset pulled low at wcnt=9 -> all outputs 0 immediately, next window full 16 cycles.
